// File: rtl/mux3_rr_arbiter_if.sv
// ============================================================================
//  Module      : mux3_rr_arbiter_if
//  Description : Request/grant/select bundle between three requesters and the
//                round-robin arbiter that steers a shared 3:1 mux.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux3_rr_arbiter_if;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       s0;
    logic       s1;
    logic       busy;

    // Requester side: raises requests, observes grants and mux selects.
    modport master (
        output req,
        input  gnt,
        input  s0,
        input  s1,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  req,
        output gnt,
        output s0,
        output s1,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/mux3_rr_arbiter.sv
// ============================================================================
//  Module      : mux3_rr_arbiter
//  Description : Round-robin arbiter for three requesters sharing one 3:1 mux.
//                Holds a grant while requested, preempts after MAX_HOLD cycles
//                when someone else waits, and drives the mux selects directly
//                (s0=1 -> i1, s1=1 -> i2, both 0 -> i0 or idle).
//                MAX_HOLD must lie in 1..15 (4-bit hold counter).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux3_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mux3_rr_arbiter_if.slave    bus
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_last;      // current owner while granting, else previous owner
    logic [3:0] r_hold_cnt;
    logic [2:0] r_gnt;
    logic       r_s0;
    logic       r_s1;
    logic       r_busy;

    logic [2:0] w_req;
    logic [2:0] w_owner_mask;
    logic       w_others;
    logic [1:0] w_idx1;
    logic [1:0] w_idx2;
    logic [1:0] w_pick;
    logic       w_grant_now;
    logic       w_go_idle;

    // Pick the next requester after r_last in 0->1->2->0 order and decide
    // whether this edge issues a new grant, releases to idle, or holds.
    always_comb begin
        w_req        = bus.req;
        w_owner_mask = 3'b001 << r_last;
        w_others     = |(w_req & ~w_owner_mask);
        w_idx1       = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_idx2       = (w_idx1 == 2'd2) ? 2'd0 : w_idx1 + 2'd1;
        // r_last itself is the last candidate, which only matters from IDLE.
        if (w_req[w_idx1])
            w_pick = w_idx1;
        else if (w_req[w_idx2])
            w_pick = w_idx2;
        else
            w_pick = r_last;

        w_grant_now = 1'b0;
        w_go_idle   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_grant_now = |w_req;
            end
            ST_GRANT: begin
                if (!w_req[r_last]) begin
                    // Owner released: hand over without a bubble if possible.
                    w_grant_now = |w_req;
                    w_go_idle   = ~(|w_req);
                end else if ((r_hold_cnt == HOLD_LIMIT) && w_others) begin
                    w_grant_now = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Arbitration state and registered grant/select outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= 2'd2;
            r_hold_cnt <= 4'd0;
            r_gnt      <= 3'b000;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_grant_now) begin
            r_state    <= ST_GRANT;
            r_last     <= w_pick;
            r_hold_cnt <= 4'd1;
            r_gnt      <= 3'b001 << w_pick;
            r_s0       <= (w_pick == 2'd1);
            r_s1       <= (w_pick == 2'd2);
            r_busy     <= 1'b1;
        end else if (w_go_idle) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 4'd0;
            r_gnt      <= 3'b000;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_busy     <= 1'b0;
        end else if ((r_state == ST_GRANT) && (r_hold_cnt != HOLD_LIMIT)) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.s0   = r_s0;
    assign bus.s1   = r_s1;
    assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mux3_rr_arbiter.sv
// ============================================================================
//  Module      : tb_mux3_rr_arbiter
//  Description : Directed and randomised checks of mux3_rr_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux3_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux3_rr_arbiter_if bus ();

    mux3_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g, input logic e0,
                           input logic e1, input logic eb);
        chk({tag, ".gnt"},  {29'd0, bus.gnt}, {29'd0, g});
        chk({tag, ".s0"},   {31'd0, bus.s0},  {31'd0, e0});
        chk({tag, ".s1"},   {31'd0, bus.s1},  {31'd0, e1});
        chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, eb});
    endtask

    logic [2:0] seq_gnt [13];
    int         wait_cnt [3];
    int         max_wait;

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.req = 3'b111;

        // ---- reset with all requesting, then RR rotation at MAX_HOLD=4 ----
        step(); step();
        chk_out("reset", 3'b000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        seq_gnt = '{3'b001, 3'b001, 3'b001, 3'b001,
                    3'b010, 3'b010, 3'b010, 3'b010,
                    3'b100, 3'b100, 3'b100, 3'b100,
                    3'b001};
        for (int i = 0; i < 13; i++) begin
            step();
            chk_out($sformatf("rot%0d", i), seq_gnt[i],
                    seq_gnt[i] == 3'b010, seq_gnt[i] == 3'b100, 1'b1);
        end

        // ---- lone requester 1 is never preempted ----
        rst_n = 1'b0;
        #2;
        rst_n   = 1'b1;
        bus.req = 3'b010;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_out($sformatf("lone%0d", i), 3'b010, 1'b1, 1'b0, 1'b1);
        end
        bus.req = 3'b000;
        step();
        chk_out("lone_drop", 3'b000, 1'b0, 1'b0, 1'b0);

        // ---- handover without bubble: 0 -> 1 -> 2 ----
        bus.req = 3'b001;
        step();
        chk_out("ho_own0", 3'b001, 1'b0, 1'b0, 1'b1);
        bus.req = 3'b110;
        step();
        chk_out("ho_to1", 3'b010, 1'b1, 1'b0, 1'b1);
        bus.req = 3'b100;
        step();
        chk_out("ho_to2", 3'b100, 1'b0, 1'b1, 1'b1);

        // ---- asynchronous reset mid-grant ----
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 3'b000, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        step();
        chk_out("after_rst", 3'b100, 1'b0, 1'b1, 1'b1);

        // ---- random requests: invariants and bounded waiting ----
        rst_n = 1'b0;
        #2;
        rst_n   = 1'b1;
        bus.req = 3'b000;
        for (int k = 0; k < 3; k++) wait_cnt[k] = 0;
        max_wait = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            // bus.req still holds the value sampled at this edge
            chk("rnd.onehot", {31'd0, $onehot0(bus.gnt)}, 32'd1);
            chk("rnd.busy",   {31'd0, bus.busy}, {31'd0, |bus.gnt});
            chk("rnd.sel",    {30'd0, bus.s1, bus.s0},
                {30'd0, bus.gnt[2], bus.gnt[1]});
            chk("rnd.toreq",  {29'd0, bus.gnt & ~bus.req}, 32'd0);
            for (int k = 0; k < 3; k++) begin
                if (bus.req[k] && !bus.gnt[k]) wait_cnt[k]++;
                else                           wait_cnt[k] = 0;
                if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
            end
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 3) == 0) bus.req[k] = ~bus.req[k];
        end
        chk("rnd.maxwait", {31'd0, max_wait <= 2 * MAX_HOLD + 1}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
